// File: rtl/intr_cond_pkg.sv
// intr_cond_pkg: interrupt source count, vector type and the SoC source map
// (which lines are edge-triggered and which are active-low).
package intr_cond_pkg;
  localparam int NUM_SOURCES = 32;
  typedef logic [NUM_SOURCES-1:0] intr_vec_t;
  localparam int SRC_UART  = 0;
  localparam int SRC_TIMER = 5;
  localparam int SRC_EXT_N = 7;
  localparam intr_vec_t GPIO_EDGE     = 32'h00FF_0000;
  localparam intr_vec_t GPIO_INV      = 32'h0F10_0000;
  localparam intr_vec_t SOC_EDGE_MASK = GPIO_EDGE | (intr_vec_t'(1) << SRC_TIMER);
  localparam intr_vec_t SOC_INV_MASK  = GPIO_INV | (intr_vec_t'(1) << SRC_EXT_N);
endpackage

// File: rtl/intr_cond_channel.sv
// intr_cond_channel: one interrupt source - synchroniser, optional glitch filter
// (INTR_DEBOUNCE_EN), level or rising-edge pulse shaping and sticky overflow flag.
module intr_cond_channel
  import intr_cond_pkg::*;
#(
  parameter bit EDGE            = 1'b0,
  parameter bit INV             = 1'b0,
  parameter int SYNC_STAGES     = 2,
  parameter int STRETCH_CYCLES  = 4,
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_raw,
  input  logic i_clr,
  output logic o_src,
  output logic o_ovf
);
  localparam int CW = $clog2(STRETCH_CYCLES + 1);
  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic                   r_p, r_q, r_ovf;
  logic                   w_f, w_rise, w_busy;
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) r_sync <= '0;
    else r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw ^ INV};
`ifdef INTR_DEBOUNCE_EN
  localparam int DW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
  logic [DW-1:0] r_dc;
  logic          r_f;
  // f only follows s once s has held its new value for DEBOUNCE_CYCLES edges
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      r_dc <= '0;
      r_f  <= 1'b0;
    end else if (r_sync[SYNC_STAGES-1] == r_f) r_dc <= '0;
    else if (r_dc == DW'(DEBOUNCE_CYCLES - 1)) begin
      r_f  <= r_sync[SYNC_STAGES-1];
      r_dc <= '0;
    end else r_dc <= r_dc + DW'(1);
  assign w_f = r_f;
`else
  assign w_f = r_sync[SYNC_STAGES-1];
`endif
  assign w_rise = w_f & ~r_p;
  assign w_busy = r_cnt != '0;
  // a rise during an active pulse reloads the counter, so the pulse stretches gap-free
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      r_p   <= 1'b0;
      r_q   <= 1'b0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else begin
      r_p   <= w_f;
      r_q   <= w_f;
      r_cnt <= (EDGE && w_rise) ? CW'(STRETCH_CYCLES) : w_busy ? r_cnt - CW'(1) : r_cnt;
      r_ovf <= EDGE && ((w_rise && w_busy) || (r_ovf && !i_clr));
    end
  assign o_src = EDGE ? w_busy : r_q;
  assign o_ovf = r_ovf;
endmodule

// File: rtl/intr_src_conditioner.sv
// intr_src_conditioner: per-source conditioning of raw interrupt lines for the PLIC.
// Define INTR_DEBOUNCE_EN to insert a DEBOUNCE_CYCLES glitch filter on every source.
module intr_src_conditioner #(
  parameter int                     NUM_SOURCES     = intr_cond_pkg::NUM_SOURCES,
  parameter int                     SYNC_STAGES     = 2,
  parameter logic [NUM_SOURCES-1:0] EDGE_MASK       = '0,
  parameter logic [NUM_SOURCES-1:0] INV_MASK        = '0,
  parameter int                     STRETCH_CYCLES  = 4,
  parameter int                     DEBOUNCE_CYCLES = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NUM_SOURCES-1:0] intr_raw_i,
  output logic [NUM_SOURCES-1:0] intr_src_o,
  output logic [NUM_SOURCES-1:0] edge_ovf_o,
  input  logic [NUM_SOURCES-1:0] edge_ovf_clr_i
);
  for (genvar i = 0; i < NUM_SOURCES; i++) begin : g_ch
    intr_cond_channel #(
      .EDGE            (EDGE_MASK[i]),
      .INV             (INV_MASK[i]),
      .SYNC_STAGES     (SYNC_STAGES),
      .STRETCH_CYCLES  (STRETCH_CYCLES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_ch (
      .i_clk (clk_i),
      .i_rst (rst_i),
      .i_raw (intr_raw_i[i]),
      .i_clr (edge_ovf_clr_i[i]),
      .o_src (intr_src_o[i]),
      .o_ovf (edge_ovf_o[i])
    );
  end
endmodule

// File: tb/tb_intr_src_conditioner.sv
// tb_intr_src_conditioner: directed and random stimulus against a history-based
// reference model of the conditioner (works with or without INTR_DEBOUNCE_EN).
module tb_intr_src_conditioner;
  import intr_cond_pkg::*;
  localparam int N = 32, SYNC = 2, STR = 4, DEB = 8, MAXC = 4096;
`ifdef INTR_DEBOUNCE_EN
  localparam int LAT = SYNC + 1 + DEB;
`else
  localparam int LAT = SYNC + 1;
`endif
  localparam logic [N-1:0] EM = SOC_EDGE_MASK, INV = SOC_INV_MASK;
  localparam logic [N-1:0] QUIET = INV, LV = ~EM & ~INV;
  localparam logic [N-1:0] B0 = 32'h1, B5 = 32'h20, B7 = 32'h80;

  logic clk = 1'b0, rst = 1'b1;
  logic [N-1:0] raw = '1, clr = '0, src, ovf;
  int checks = 0, errors = 0;

  intr_src_conditioner #(
    .NUM_SOURCES (N), .SYNC_STAGES (SYNC), .EDGE_MASK (EM), .INV_MASK (INV),
    .STRETCH_CYCLES (STR), .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .clk_i (clk), .rst_i (rst), .intr_raw_i (raw), .intr_src_o (src),
    .edge_ovf_o (ovf), .edge_ovf_clr_i (clr)
  );

  always #5 clk = ~clk;

  // model: histories indexed by edge number since reset release
  logic [N-1:0] xh [MAXC];
  logic [N-1:0] fh [MAXC];
  logic [N-1:0] rh [MAXC];
  int n = 0, base = 1;
  logic [N-1:0] exp_src = '0, exp_ovf = '0;

  function automatic logic [N-1:0] hx(int k); return k < base ? '0 : xh[k]; endfunction
  function automatic logic [N-1:0] hf(int k); return k < base ? '0 : fh[k]; endfunction
  function automatic logic [N-1:0] hr(int k); return k < base ? '0 : rh[k]; endfunction

  task automatic tick(input logic [N-1:0] r, input logic [N-1:0] c);
    logic [N-1:0] win, prev_on;
    raw = r;
    clr = c;
    @(posedge clk);
    n++;
    xh[n] = r ^ INV;
`ifdef INTR_DEBOUNCE_EN
    begin
      logic [N-1:0] fp, st;
      fp = hf(n - 1);
      st = '1;
      for (int j = 1; j <= DEB; j++) st &= hx(n - j - SYNC + 1) ^ fp;
      fh[n] = fp ^ st;
    end
`else
    fh[n] = hx(n - SYNC + 1);
`endif
    rh[n] = hf(n - 1) & ~hf(n - 2) & EM;
    win = '0;
    prev_on = '0;
    for (int j = 0; j < STR; j++) win |= hr(n - j);
    for (int j = 1; j <= STR; j++) prev_on |= hr(n - j);
    exp_ovf = EM & ((rh[n] & prev_on) | (exp_ovf & ~c));
    exp_src = (EM & win) | (~EM & hf(n - 1));
    @(negedge clk);
  endtask

  task automatic rst_pulse(input logic [N-1:0] hold);
    @(negedge clk);
    rst = 1'b1;
    raw = hold;
    clr = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (src !== '0 || ovf !== '0) begin
      errors++;
      $display("FAIL reset_hold src=%h ovf=%h want 0", src, ovf);
    end
    rst = 1'b0;
    base = n + 1;
    exp_src = '0;
    exp_ovf = '0;
  endtask

  task automatic settle();
    for (int k = 0; k < LAT + STR + 4; k++) begin
      tick(QUIET, '0);
      checks++;
      if (src !== exp_src || ovf !== exp_ovf) begin
        errors++;
        $display("FAIL settle n=%0d src=%h want %h ovf=%h want %h", n, src, exp_src, ovf, exp_ovf);
      end
    end
  endtask

  task automatic test_reset();
    rst_pulse('1);
    for (int k = 1; k <= LAT + STR + 2; k++) begin
      tick('1, '0);
      checks++;
      if (src !== exp_src || ovf !== exp_ovf) begin
        errors++;
        $display("FAIL reset_model k=%0d src=%h want %h ovf=%h want %h", k, src, exp_src, ovf, exp_ovf);
      end
      if (k == 1) begin
        checks++;
        if (src !== '0 || ovf !== '0) begin
          errors++;
          $display("FAIL reset_first_cycle src=%h ovf=%h want 0", src, ovf);
        end
      end
      if (k == LAT - 1 || k == LAT) begin
        checks++;
        if ((src & LV) !== (k == LAT ? LV : '0)) begin
          errors++;
          $display("FAIL reset_level_latency k=%0d got=%h want=%h", k, src & LV, k == LAT ? LV : '0);
        end
      end
    end
    settle();
  endtask

  task automatic test_level();
    for (int k = 1; k <= 30 + LAT + 4; k++) begin
      tick((k > 10 && k <= 30) ? QUIET | B0 : QUIET, '0);
      checks++;
      if (src !== exp_src || ovf !== exp_ovf) begin
        errors++;
        $display("FAIL level_model k=%0d src=%h want %h", k, src, exp_src);
      end
      checks++;
      if (src[0] !== (k >= 10 + LAT && k < 30 + LAT)) begin
        errors++;
        $display("FAIL level_src0 k=%0d got=%b want=%b", k, src[0], k >= 10 + LAT && k < 30 + LAT);
      end
    end
  endtask

  task automatic test_edge();
    int hi = 0;
    for (int k = 1; k <= 20 + LAT + STR; k++) begin
      tick(k <= 20 ? QUIET | B5 : QUIET, '0);
      hi += int'(src[5]);
      checks++;
      if (src !== exp_src || ovf !== exp_ovf) begin
        errors++;
        $display("FAIL edge_model k=%0d src=%h want %h ovf=%h want %h", k, src, exp_src, ovf, exp_ovf);
      end
      checks++;
      if (src[5] !== (k >= LAT && k < LAT + STR) || ovf[5] !== 1'b0) begin
        errors++;
        $display("FAIL edge_pulse k=%0d src5=%b ovf5=%b want %b/0", k, src[5], ovf[5], k >= LAT && k < LAT + STR);
      end
    end
    checks++;
    if (hi != STR) begin
      errors++;
      $display("FAIL edge_width got=%0d want=%0d", hi, STR);
    end
  endtask

  task automatic test_retrigger();
    for (int ph = 0; ph < 2; ph++) begin
      for (int k = 1; k <= LAT + STR + 6; k++) begin
        tick((k == 1 || k == 3) ? QUIET | B5 : QUIET, (ph == 1 && k == LAT + 2) ? B5 : '0);
        checks++;
        if (src !== exp_src || ovf !== exp_ovf) begin
          errors++;
          $display("FAIL retrig_model ph=%0d k=%0d src=%h want %h ovf=%h want %h", ph, k, src, exp_src, ovf, exp_ovf);
        end
`ifndef INTR_DEBOUNCE_EN
        checks++;
        if (src[5] !== (k >= LAT && k < LAT + STR + 2) || ovf[5] !== (ph == 1 || k >= LAT + 2)) begin
          errors++;
          $display("FAIL retrig_pulse ph=%0d k=%0d src5=%b ovf5=%b want %b/%b", ph, k, src[5], ovf[5],
                   k >= LAT && k < LAT + STR + 2, ph == 1 || k >= LAT + 2);
        end
`endif
      end
    end
    tick(QUIET, B5);
    checks++;
    if (ovf[5] !== 1'b0 || ovf !== exp_ovf) begin
      errors++;
      $display("FAIL ovf_clear got=%h want=%h", ovf, exp_ovf);
    end
  endtask

  task automatic test_inversion();
    rst_pulse(QUIET & ~B7);
    for (int ph = 0; ph < 2; ph++) begin
      for (int k = 1; k <= LAT + 2; k++) begin
        tick(QUIET & ~B7, '0);
        checks++;
        if (src !== exp_src || src[7] !== (k >= LAT)) begin
          errors++;
          $display("FAIL inv_src7 ph=%0d k=%0d got=%h want=%h bit7 %b", ph, k, src, exp_src, k >= LAT);
        end
      end
      settle();
    end
  endtask

  task automatic test_debounce();
`ifdef INTR_DEBOUNCE_EN
    for (int k = 1; k <= 30; k++) begin
      tick(k <= 5 ? QUIET | B0 : QUIET, '0);
      checks++;
      if (src[0] !== 1'b0 || src !== exp_src) begin
        errors++;
        $display("FAIL deb_glitch k=%0d got=%h want=%h", k, src, exp_src);
      end
    end
    for (int k = 1; k <= 12 + LAT + 2; k++) begin
      tick(k <= 12 ? QUIET | B0 : QUIET, '0);
      checks++;
      if (src[0] !== (k >= LAT && k < 12 + LAT) || src !== exp_src) begin
        errors++;
        $display("FAIL deb_pulse k=%0d got=%h want=%h", k, src, exp_src);
      end
    end
`endif
  endtask

  task automatic test_mid_reset();
    for (int k = 1; k <= LAT; k++) tick(QUIET | B5, '0);
    checks++;
    if (src[5] !== 1'b1) begin
      errors++;
      $display("FAIL midrst_pulse got=%b want=1", src[5]);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (src !== '0 || ovf !== '0) begin
      errors++;
      $display("FAIL midrst_async src=%h ovf=%h want 0", src, ovf);
    end
    @(negedge clk);
    raw = QUIET;
    rst = 1'b0;
    base = n + 1;
    exp_src = '0;
    exp_ovf = '0;
    settle();
  endtask

  task automatic test_random();
    logic [N-1:0] r = QUIET, c;
    for (int k = 0; k < 1500; k++) begin
      r ^= (k < 750) ? $urandom & $urandom & $urandom
                     : $urandom & $urandom & $urandom & $urandom & $urandom & $urandom;
      c = $urandom & $urandom & $urandom;
      tick(r, c);
      checks++;
      if (src !== exp_src || ovf !== exp_ovf) begin
        errors++;
        $display("FAIL random n=%0d src=%h want %h ovf=%h want %h", n, src, exp_src, ovf, exp_ovf);
      end
    end
    settle();
  endtask

  initial begin
    test_reset();
    test_level();
    test_edge();
    test_retrigger();
    test_inversion();
    test_debounce();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
